// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with parity/stop/timeout checking.
// Define PS2_RX_FIFO_EN to buffer received bytes in a 2**FIFO_BITS-entry FIFO.
module ps2_rx #(
    parameter int TIMEOUT   = 4096,
    parameter int FIFO_BITS = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       rx_overflow,
    output logic       rx_busy
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state_q;
    logic [2:0]  clk_sync_q;
    logic [1:0]  dat_sync_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [15:0] idle_cnt_q;
    logic        par_ok_q;
    logic        fall, bit_s, expire, good;

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_s   = dat_sync_q[1];
    assign expire  = (state_q != IDLE) && (idle_cnt_q == 16'(TIMEOUT));
    assign good    = fall && !expire && (state_q == STOP) && bit_s && par_ok_q;
    assign rx_busy = state_q != IDLE;

    // Synchronizers reset high so releasing reset never looks like a falling edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            clk_sync_q    <= '1;
            dat_sync_q    <= '1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            idle_cnt_q    <= '0;
            par_ok_q      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_timeout    <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q    <= {dat_sync_q[0], ps2_data};
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_timeout    <= 1'b0;
            idle_cnt_q    <= (state_q == IDLE || fall) ? 16'd0 : idle_cnt_q + 16'd1;
            if (expire) begin
                state_q    <= IDLE;
                rx_timeout <= 1'b1;
                idle_cnt_q <= 16'd0;
            end else if (fall) begin
                case (state_q)
                    IDLE: if (!bit_s) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                    DATA: begin
                        shift_q   <= {bit_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_ok_q <= ^{shift_q, bit_s};
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q       <= IDLE;
                        rx_parity_err <= !par_ok_q;
                        rx_frame_err  <= par_ok_q && !bit_s;
                    end
                endcase
            end
        end
    end

`ifdef PS2_RX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_BITS;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wr_q, rd_q;
    logic [FIFO_BITS:0]   cnt_q;
    logic                 full, pop, push;

    assign full     = cnt_q == (FIFO_BITS+1)'(DEPTH);
    assign pop      = rx_rd && cnt_q != '0;
    assign push     = good && (!full || pop);
    assign rx_valid = cnt_q != '0;
    assign rx_data  = mem_q[rd_q];

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_q] <= shift_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            wr_q        <= wr_q + FIFO_BITS'(push);
            rd_q        <= rd_q + FIFO_BITS'(pop);
            cnt_q       <= cnt_q + (FIFO_BITS+1)'(push) - (FIFO_BITS+1)'(pop);
            rx_overflow <= good && full && !pop;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = rx_rd ^ (FIFO_BITS > 0);
    assign rx_overflow = 1'b0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= good;
            if (good) rx_data <= shift_q;
        end
    end
`endif
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed scenario tests for ps2_rx (FIFO scenario only when PS2_RX_FIFO_EN is defined).
module tb_ps2_rx;
    localparam int TO = 300;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_rd;
    logic       auto_rd = 1'b1;
    logic       man_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_timeout, rx_overflow, rx_busy;

    int tests = 0;
    int fails = 0;
    int n_valid, n_perr, n_ferr, n_tout, n_ovf;
    logic [7:0] cap [8];

    assign rx_rd = auto_rd ? rx_valid : man_rd;

    ps2_rx #(.TIMEOUT(TO), .FIFO_BITS(2)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_timeout(rx_timeout), .rx_overflow(rx_overflow), .rx_busy(rx_busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (rx_valid) begin
                if (n_valid < 8) cap[n_valid] = rx_data;
                n_valid++;
            end
            n_perr += int'(rx_parity_err);
            n_ferr += int'(rx_frame_err);
            n_tout += int'(rx_timeout);
            n_ovf  += int'(rx_overflow);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clr;
        n_valid = 0; n_perr = 0; n_ferr = 0; n_tout = 0; n_ovf = 0;
    endtask

    // bits[0] goes out first; each bit is one 84-cycle PS/2 clock period.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cyc(21);
            ps2_clk = 1'b0;
            cyc(42);
            ps2_clk = 1'b1;
            cyc(21);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bits({stp, par, d, 1'b0}, 11);
    endtask

    task automatic test_reset;
        cyc(3);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        tests++; if ({rx_parity_err, rx_frame_err, rx_timeout, rx_overflow} !== 4'b0) begin fails++; $display("FAIL reset_strobes got=%b exp=0000", {rx_parity_err, rx_frame_err, rx_timeout, rx_overflow}); end
`ifndef PS2_RX_FIFO_EN
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", rx_data); end
`endif
        reset_n = 1'b1;
        clr();
        cyc(10);
        tests++; if (n_valid !== 0 || rx_busy !== 1'b0) begin fails++; $display("FAIL reset_release valid=%0d busy=%b exp=0/0", n_valid, rx_busy); end
    endtask

    task automatic test_good;
        clr();
        send_frame(8'h1C, 1'b0, 1'b1);
        tests++; if (n_valid !== 1) begin fails++; $display("FAIL good_count got=%0d exp=1", n_valid); end
        tests++; if (cap[0] !== 8'h1C) begin fails++; $display("FAIL good_data got=%h exp=1c", cap[0]); end
        tests++; if (n_perr + n_ferr + n_tout + n_ovf !== 0) begin fails++; $display("FAIL good_errs got=%0d exp=0", n_perr + n_ferr + n_tout + n_ovf); end
`ifndef PS2_RX_FIFO_EN
        tests++; if (rx_data !== 8'h1C) begin fails++; $display("FAIL good_hold got=%h exp=1c", rx_data); end
`endif
    endtask

    task automatic test_idle_noise;
        clr();
        send_bits(11'h7FF, 1);
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL noise_busy got=%b exp=0", rx_busy); end
        tests++; if (n_valid + n_perr + n_ferr + n_tout !== 0) begin fails++; $display("FAIL noise_strobes got=%0d exp=0", n_valid + n_perr + n_ferr + n_tout); end
    endtask

    task automatic test_parity;
        clr();
        send_frame(8'hF0, 1'b0, 1'b1);
        tests++; if (n_perr !== 1) begin fails++; $display("FAIL parity_err got=%0d exp=1", n_perr); end
        tests++; if (n_valid !== 0 || n_ferr !== 0) begin fails++; $display("FAIL parity_side valid=%0d ferr=%0d exp=0/0", n_valid, n_ferr); end
`ifndef PS2_RX_FIFO_EN
        tests++; if (rx_data !== 8'h1C) begin fails++; $display("FAIL parity_hold got=%h exp=1c", rx_data); end
`endif
        clr();
        send_frame(8'hF0, 1'b1, 1'b1);
        tests++; if (n_valid !== 1 || cap[0] !== 8'hF0) begin fails++; $display("FAIL parity_retry count=%0d data=%h exp=1/f0", n_valid, cap[0]); end
    endtask

    task automatic test_frame;
        clr();
        send_frame(8'h5A, 1'b1, 1'b0);
        tests++; if (n_ferr !== 1 || n_perr !== 0) begin fails++; $display("FAIL frame_err ferr=%0d perr=%0d exp=1/0", n_ferr, n_perr); end
        tests++; if (n_valid !== 0 || rx_busy !== 1'b0) begin fails++; $display("FAIL frame_side valid=%0d busy=%b exp=0/0", n_valid, rx_busy); end
        clr();
        send_frame(8'h5A, 1'b0, 1'b0);
        tests++; if (n_perr !== 1 || n_ferr !== 0 || n_valid !== 0) begin fails++; $display("FAIL frame_prio perr=%0d ferr=%0d valid=%0d exp=1/0/0", n_perr, n_ferr, n_valid); end
    endtask

    task automatic test_timeout;
        clr();
        send_bits(11'b000_0000_1010, 4);
        tests++; if (rx_busy !== 1'b1 || n_tout !== 0) begin fails++; $display("FAIL tout_pre busy=%b tout=%0d exp=1/0", rx_busy, n_tout); end
        cyc(TO + 20);
        tests++; if (n_tout !== 1) begin fails++; $display("FAIL tout_pulse got=%0d exp=1", n_tout); end
        tests++; if (rx_busy !== 1'b0 || n_valid !== 0) begin fails++; $display("FAIL tout_idle busy=%b valid=%0d exp=0/0", rx_busy, n_valid); end
        clr();
        send_frame(8'h12, 1'b1, 1'b1);
        tests++; if (n_valid !== 1 || cap[0] !== 8'h12 || n_perr + n_ferr + n_tout !== 0) begin fails++; $display("FAIL tout_next count=%0d data=%h errs=%0d exp=1/12/0", n_valid, cap[0], n_perr + n_ferr + n_tout); end
    endtask

    task automatic test_reset_mid;
        clr();
        send_bits({2'b11, 8'h33, 1'b0}, 5);
        reset_n = 1'b0;
        cyc(3);
        tests++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin fails++; $display("FAIL rmid_state busy=%b valid=%b exp=0/0", rx_busy, rx_valid); end
`ifndef PS2_RX_FIFO_EN
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rmid_data got=%h exp=00", rx_data); end
`endif
        reset_n = 1'b1;
        cyc(TO + 20);
        tests++; if (n_valid + n_perr + n_ferr + n_tout !== 0) begin fails++; $display("FAIL rmid_strobes got=%0d exp=0", n_valid + n_perr + n_ferr + n_tout); end
        clr();
        send_frame(8'h44, 1'b1, 1'b1);
        tests++; if (n_valid !== 1 || cap[0] !== 8'h44) begin fails++; $display("FAIL rmid_next count=%0d data=%h exp=1/44", n_valid, cap[0]); end
    endtask

    task automatic test_back_to_back;
        clr();
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        tests++; if (n_valid !== 2) begin fails++; $display("FAIL b2b_count got=%0d exp=2", n_valid); end
        tests++; if (cap[0] !== 8'hA5 || cap[1] !== 8'h00) begin fails++; $display("FAIL b2b_data got=%h,%h exp=a5,00", cap[0], cap[1]); end
    endtask

`ifdef PS2_RX_FIFO_EN
    task automatic test_fifo;
        logic [7:0] exp_d [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic       exp_p [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        auto_rd = 1'b0;
        clr();
        for (int i = 0; i < 4; i++) send_frame(exp_d[i], exp_p[i], 1'b1);
        tests++; if (n_ovf !== 0) begin fails++; $display("FAIL fifo_ovf_early got=%0d exp=0", n_ovf); end
        send_frame(exp_d[4], exp_p[4], 1'b1);
        tests++; if (n_ovf !== 1) begin fails++; $display("FAIL fifo_ovf got=%0d exp=1", n_ovf); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rx_valid !== 1'b1 || rx_data !== exp_d[i]) begin fails++; $display("FAIL fifo_read%0d valid=%b data=%h exp=1/%h", i, rx_valid, rx_data, exp_d[i]); end
            man_rd = 1'b1;
            cyc(1);
            man_rd = 1'b0;
        end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL fifo_empty got=%b exp=0", rx_valid); end
        man_rd = 1'b1;
        cyc(1);
        man_rd = 1'b0;
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL fifo_pop_empty got=%b exp=0", rx_valid); end
        auto_rd = 1'b1;
    endtask
`endif

    initial begin
        clr();
        test_reset();
        test_good();
        test_idle_noise();
        test_parity();
        test_frame();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef PS2_RX_FIFO_EN
        test_fifo();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
